// File: rtl/axis_packet_buffer.sv
// AXI4-Stream store-and-forward buffer: inferred RAM plus a two-stage read pipeline
// (registered RAM output, then output register), with optional whole-packet gating.
module axis_packet_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int PACKET_MODE = 0
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic [ADDR_WIDTH:0]     fill_count,
  output logic [ADDR_WIDTH:0]     packet_count,
  output logic                    buf_full,
  output logic                    buf_empty,
  output logic                    pkt_oversize
);
  localparam int SW    = DATA_WIDTH / 8;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic            last;
    logic [SW-1:0]   strb;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  word_t mem [DEPTH];
  logic  last_mem [DEPTH];
  word_t ram_q, out_q;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fill, pkts, uniss, upkts;
  logic [CW-1:0] fill_nxt;
  logic [1:0]    vld_pipe;
  logic          rdy, force_rel, oversize;
  logic          wr_hs, rd_hs, s1_adv, s1_free, gate, issue, rd_last;

  assign wr_hs   = s01_axis_tvalid && rdy;
  assign rd_hs   = vld_pipe[1] && m01_axis_tready;
  assign s1_adv  = vld_pipe[0] && (!vld_pipe[1] || m01_axis_tready);
  assign s1_free = !vld_pipe[0] || s1_adv;
  assign rd_last = last_mem[rd_ptr];
  assign issue   = (uniss != '0) && s1_free && gate;
  assign fill_nxt = fill + CW'(wr_hs) - CW'(rd_hs);

  // upkts counts complete packets whose tlast has not yet been issued to the pipeline
  always_comb begin
    gate = 1'b1;
    if (PACKET_MODE != 0) gate = (upkts != '0) || force_rel;
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_hs) begin
      mem[wr_ptr]      <= '{last: s01_axis_tlast, strb: s01_axis_tstrb, data: s01_axis_tdata};
      last_mem[wr_ptr] <= s01_axis_tlast;
    end
    if (issue) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      pkts      <= '0;
      uniss     <= '0;
      upkts     <= '0;
      vld_pipe  <= '0;
      rdy       <= 1'b0;
      out_q     <= '0;
      force_rel <= 1'b0;
      oversize  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + ADDR_WIDTH'(wr_hs);
      rd_ptr   <= rd_ptr + ADDR_WIDTH'(issue);
      fill     <= fill_nxt;
      rdy      <= fill_nxt != DEPTH_C;
      pkts     <= pkts + CW'(wr_hs && s01_axis_tlast) - CW'(rd_hs && out_q.last);
      uniss    <= uniss + CW'(wr_hs) - CW'(issue);
      upkts    <= upkts + CW'(wr_hs && s01_axis_tlast) - CW'(issue && rd_last);
      vld_pipe[0] <= issue || (vld_pipe[0] && !s1_adv);
      vld_pipe[1] <= s1_adv || (vld_pipe[1] && !m01_axis_tready);
      if (s1_adv) out_q <= ram_q;
      // full with no complete packet would deadlock; release cut-through until a tlast issues
      if (PACKET_MODE != 0) begin
        if (force_rel) begin
          if (issue && rd_last) force_rel <= 1'b0;
        end else if (buf_full && pkts == '0) begin
          force_rel <= 1'b1;
          oversize  <= 1'b1;
        end
      end
    end
  end

  assign s01_axis_tready = rdy;
  assign m01_axis_tvalid = vld_pipe[1];
  assign m01_axis_tdata  = out_q.data;
  assign m01_axis_tstrb  = out_q.strb;
  assign m01_axis_tlast  = out_q.last;
  assign fill_count      = fill;
  assign packet_count    = pkts;
  assign buf_full        = fill == DEPTH_C;
  assign buf_empty       = fill == '0;
  assign pkt_oversize    = oversize;
endmodule

// File: tb/tb_axis_packet_buffer.sv
// Directed bench: one cut-through and one packet-mode buffer share the same input stimulus.
module tb_axis_packet_buffer;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [3:0]    s_strb = 4'hF;
  logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;

  logic [DW-1:0] c_md, p_md;
  logic [3:0]    c_ms, p_ms;
  logic          c_sr, c_mv, c_ml, c_full, c_empty, c_ovr;
  logic          p_sr, p_mv, p_ml, p_full, p_empty, p_ovr;
  logic [AW:0]   c_fill, c_pkt, p_fill, p_pkt;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  axis_packet_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_MODE(0)) u_cut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s01_axis_tdata(s_data), .s01_axis_tstrb(s_strb), .s01_axis_tvalid(s_valid),
    .s01_axis_tlast(s_last), .s01_axis_tready(c_sr),
    .m01_axis_tdata(c_md), .m01_axis_tstrb(c_ms), .m01_axis_tvalid(c_mv),
    .m01_axis_tlast(c_ml), .m01_axis_tready(m_ready),
    .fill_count(c_fill), .packet_count(c_pkt), .buf_full(c_full),
    .buf_empty(c_empty), .pkt_oversize(c_ovr));

  axis_packet_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_MODE(1)) u_pkt (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s01_axis_tdata(s_data), .s01_axis_tstrb(s_strb), .s01_axis_tvalid(s_valid),
    .s01_axis_tlast(s_last), .s01_axis_tready(p_sr),
    .m01_axis_tdata(p_md), .m01_axis_tstrb(p_ms), .m01_axis_tvalid(p_mv),
    .m01_axis_tlast(p_ml), .m01_axis_tready(m_ready),
    .fill_count(p_fill), .packet_count(p_pkt), .buf_full(p_full),
    .buf_empty(p_empty), .pkt_oversize(p_ovr));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic [3:0] st, input logic l);
    s_valid = 1'b1; s_data = d; s_strb = st; s_last = l;
    tick();
    s_valid = 1'b0; s_last = 1'b0; s_strb = 4'hF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // collects n words in order from the chosen buffer, bounded in cycles
  task automatic drain(input bit pk, input logic [DW-1:0] base, input int n);
    int got = 0;
    for (int cyc = 0; cyc < 64 && got < n; cyc++) begin
      if (pk ? p_mv : c_mv) begin
        chk(pk ? "pkt_drain_data" : "cut_drain_data", pk ? p_md : c_md, 64'(base + DW'(got)));
        got++;
      end
      tick();
    end
    chk("drain_count", 64'(got), 64'(n));
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_sready", c_sr, 0);
    chk("rst_mvalid", c_mv, 0);
    chk("rst_fill", c_fill, 0);
    chk("rst_mdata", c_md, 0);
    chk("rst_ovr", p_ovr, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_sready", c_sr, 1);
    chk("post_rst_empty", c_empty, 1);

    // three-word packet, latency and ordering
    m_ready = 1'b1;
    put(32'h11, 4'h1, 1'b0);
    chk("t1_fill1", c_fill, 1);
    chk("t1_mv_e1", c_mv, 0);
    put(32'h22, 4'h3, 1'b0);
    chk("t1_mv_e2", c_mv, 0);
    chk("t1_pkt0", c_pkt, 0);
    put(32'h33, 4'hF, 1'b1);
    chk("t1_mv_e3", c_mv, 1);
    chk("t1_d0", c_md, 32'h11);
    chk("t1_s0", c_ms, 4'h1);
    chk("t1_l0", c_ml, 0);
    chk("t1_pkt1", c_pkt, 1);
    chk("t1_fill3", c_fill, 3);
    tick();
    chk("t1_d1", c_md, 32'h22);
    chk("t1_l1", c_ml, 0);
    tick();
    chk("t1_d2", c_md, 32'h33);
    chk("t1_s2", c_ms, 4'hF);
    chk("t1_l2", c_ml, 1);
    tick();
    chk("t1_mv_end", c_mv, 0);
    chk("t1_fill_end", c_fill, 0);
    chk("t1_pkt_end", c_pkt, 0);

    // fill to capacity with output stalled
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) put(DW'(i), 4'hF, 1'b0);
    chk("t2_full", c_full, 1);
    chk("t2_sready", c_sr, 0);
    chk("t2_fill16", c_fill, 16);
    s_valid = 1'b1; s_data = 32'h99;
    tick(); tick(); tick();
    chk("t2_fill_held", c_fill, 16);
    chk("t2_mv_held", c_mv, 1);
    chk("t2_md_held", c_md, 0);
    // read while full with a write offered: no write may slip in
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0; m_ready = 1'b0;
    chk("t3_fill15", c_fill, 15);
    chk("t3_sready", c_sr, 1);
    chk("t3_full", c_full, 0);
    m_ready = 1'b1;
    drain(1'b0, 32'h1, 15);
    chk("t2_empty", c_empty, 1);
    chk("t2_fill0", c_fill, 0);

    // reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) put(32'hA0 + DW'(i), 4'hF, i == 2);
    chk("t6_fill7", c_fill, 7);
    chk("t6_pkt1", c_pkt, 1);
    chk("t6_mv", c_mv, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_fill0", c_fill, 0);
    chk("t6_pkt0", c_pkt, 0);
    chk("t6_mv0", c_mv, 0);
    m_ready = 1'b1;
    tick();
    chk("t6_sready", c_sr, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_old", c_mv, 0);
      tick();
    end
    put(32'h5A, 4'hF, 1'b1);
    drain(1'b0, 32'h5A, 1);

    // packet mode: output held until tlast is stored
    do_reset();
    m_ready = 1'b1;
    put(32'h40, 4'hF, 1'b0);
    put(32'h41, 4'hF, 1'b0);
    put(32'h42, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_gated", p_mv, 0);
      tick();
    end
    put(32'h43, 4'hF, 1'b1);
    chk("t4_mv_e", p_mv, 0);
    chk("t4_pkt", p_pkt, 1);
    tick();
    chk("t4_mv_e1", p_mv, 0);
    tick();
    chk("t4_mv_e2", p_mv, 1);
    chk("t4_d0", p_md, 32'h40);
    tick();
    chk("t4_d1", p_md, 32'h41);
    tick();
    chk("t4_d2", p_md, 32'h42);
    chk("t4_l2", p_ml, 0);
    tick();
    chk("t4_d3", p_md, 32'h43);
    chk("t4_l3", p_ml, 1);
    chk("t4_s3", p_ms, 4'hF);
    tick();
    chk("t4_mv_end", p_mv, 0);
    chk("t4_empty", p_empty, 1);

    // packet mode oversize: a full buffer with no tlast is forced out
    for (int i = 0; i < 16; i++) put(32'h100 + DW'(i), 4'hF, 1'b0);
    chk("t5_full", p_full, 1);
    chk("t5_fill16", p_fill, 16);
    chk("t5_sready", p_sr, 0);
    chk("t5_mv0", p_mv, 0);
    chk("t5_ovr_pre", p_ovr, 0);
    tick();
    chk("t5_ovr_set", p_ovr, 1);
    drain(1'b1, 32'h100, 16);
    put(32'h200, 4'hF, 1'b0);
    put(32'h201, 4'hF, 1'b1);
    drain(1'b1, 32'h200, 2);
    put(32'h300, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_regated", p_mv, 0);
      tick();
    end
    put(32'h301, 4'hF, 1'b1);
    drain(1'b1, 32'h300, 2);
    chk("t5_ovr_sticky", p_ovr, 1);
    chk("t5_cut_ovr", c_ovr, 0);
    do_reset();
    chk("t5_ovr_clr", p_ovr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
